// File: rtl/mem_line_server.sv
// Line-granular main-memory responder: one outstanding request, fixed access
// latency, then a streamed read line or an absorbed write line.
module mem_line_server #(
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 16,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [31:0]       wdata,
    output logic              rdata_valid,
    output logic [31:0]       rdata,
    output logic              rdata_last,
    output logic              wr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int HI_W  = ADDR_W - OFF_W;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAT,
        S_RBURST,
        S_WBURST,
        S_WRESP
    } state_t;

    typedef logic [31:0] mem_t [DEPTH];

    // The store powers up holding its own word addresses.
    function automatic mem_t init_store();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    mem_t             r_mem = init_store();
    state_t           r_state;
    state_t           w_next_state;
    logic [HI_W-1:0]  r_line;
    logic             r_write;
    logic [LAT_W-1:0] r_lat;
    logic [OFF_W-1:0] r_beat;
    logic [31:0]      r_rdata;
    logic             r_rdata_last;

    logic              w_accept;
    logic              w_rd_issue;
    logic              w_wr_beat;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused;

    // Offset bits of the request are discarded: the line always starts at its base.
    assign w_unused = ^req_addr[OFF_W-1:0];
    assign w_addr   = {r_line, r_beat};

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output and strobe gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rd_issue   = 1'b0;
        w_wr_beat    = 1'b0;
        req_ready    = 1'b0;
        wdata_ready  = 1'b0;
        rdata_valid  = 1'b0;
        wr_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LAT;
                end
            end
            S_LAT: begin
                if (r_lat == '0) begin
                    w_rd_issue   = !r_write;
                    w_next_state = r_write ? S_WBURST : S_RBURST;
                end
            end
            S_RBURST: begin
                rdata_valid = 1'b1;
                // The beat on display is the last one: this edge ends the line.
                if (r_rdata_last) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_rd_issue = 1'b1;
                end
            end
            S_WBURST: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    w_wr_beat = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_next_state = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                wr_done      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line       <= '0;
            r_write      <= 1'b0;
            r_lat        <= '0;
            r_beat       <= '0;
            r_rdata      <= '0;
            r_rdata_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_line  <= req_addr[ADDR_W-1:OFF_W];
                r_write <= req_write;
                r_lat   <= LAT_W'(LATENCY - 1);
                r_beat  <= '0;
            end else if (r_state == S_LAT && r_lat != '0) begin
                r_lat <= r_lat - 1'b1;
            end
            if (w_rd_issue || w_wr_beat) begin
                r_beat <= r_beat + 1'b1;
            end
            // Each read beat is loaded at the edge that starts its cycle.
            if (w_rd_issue) begin
                r_rdata <= r_mem[w_addr];
            end
            r_rdata_last <= w_rd_issue && (r_beat == LAST_BEAT);
        end
    end

    // NOTE: the store has no reset; contents survive rst, and partial write
    // lines stay committed.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[w_addr] <= wdata;
        end
    end

    assign rdata      = r_rdata;
    assign rdata_last = r_rdata_last;

endmodule

// File: tb/tb_mem_line_server.sv
// Directed bench for mem_line_server: reads, gapped writes, back-to-back
// requests, top-of-memory line, mid-write reset and early write beats.
module tb_mem_line_server;

    localparam int LAT = 4;
    localparam int LW  = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        rdata_last;
    logic        wr_done;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [0:65535];

    mem_line_server #(
        .ADDR_W    (16),
        .LINE_WORDS(LW),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata      (wdata),
        .rdata_valid(rdata_valid),
        .rdata      (rdata),
        .rdata_last (rdata_last),
        .wr_done    (wr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // Read one line; the bench sits just after an edge with the DUT idle.
    task automatic do_read(input logic [15:0] addr, input string tag);
        logic [15:0] base;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_d;
        base = addr & 16'hFFF0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_pre: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n <= LAT + LW; n++) begin
            exp_valid = (n >= LAT) && (n < LAT + LW);
            exp_ready = (n == LAT + LW);
            checks++;
            if (rdata_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s_valid n=%0d: got %b want %b", tag, n, rdata_valid, exp_valid);
            end
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL %s_req_ready n=%0d: got %b want %b", tag, n, req_ready, exp_ready);
            end
            if (exp_valid || n == LAT + LW) begin
                exp_d = exp_valid ? model[base + 16'(n - LAT)] : model[base + 16'(LW - 1)];
                checks++;
                if (rdata !== exp_d) begin
                    errors++;
                    $display("FAIL %s_data n=%0d: got %h want %h", tag, n, rdata, exp_d);
                end
                checks++;
                if (rdata_last !== (n == LAT + LW - 1)) begin
                    errors++;
                    $display("FAIL %s_last n=%0d: got %b want %b", tag, n, rdata_last, (n == LAT + LW - 1));
                end
            end
            if (n < LAT + LW) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Write one line, optionally with gaps and with wdata_valid held during latency.
    task automatic do_write(input logic [15:0] addr, input logic [31:0] dbase,
                            input logic gaps, input logic lat_valid, input string tag);
        logic [15:0] base;
        logic        exp_ready;
        logic        exp_done;
        int          k;
        int          finish_n;
        int          pulses;
        base     = addr & 16'hFFF0;
        k        = 0;
        finish_n = -1;
        pulses   = 0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_pre: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        for (int n = 0; n <= LAT + 2 * LW + 1; n++) begin
            exp_ready = (n >= LAT) && (k < LW);
            exp_done  = (n == finish_n);
            checks++;
            if (wdata_ready !== exp_ready) begin
                errors++;
                $display("FAIL %s_wready n=%0d: got %b want %b", tag, n, wdata_ready, exp_ready);
            end
            checks++;
            if (wr_done !== exp_done) begin
                errors++;
                $display("FAIL %s_wr_done n=%0d: got %b want %b", tag, n, wr_done, exp_done);
            end
            checks++;
            if (req_ready !== (finish_n >= 0 && n > finish_n)) begin
                errors++;
                $display("FAIL %s_req_ready n=%0d: got %b want %b", tag, n, req_ready, (finish_n >= 0 && n > finish_n));
            end
            if (wr_done === 1'b1) pulses++;
            if (n < LAT) begin
                wdata_valid = lat_valid;
                wdata       = 32'hDEAD_BEEF;
            end else if (k < LW) begin
                wdata_valid = gaps ? (((n - LAT) % 2) == 0) : 1'b1;
                wdata       = dbase + 32'(k);
            end else begin
                wdata_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (exp_ready && wdata_valid) begin
                model[base + 16'(k)] = wdata;
                k++;
                if (k == LW) finish_n = n + 1;
            end
        end
        wdata_valid = 1'b0;
        checks++;
        if (k !== LW) begin
            errors++;
            $display("FAIL %s_beats: got %0d want %0d", tag, k, LW);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d want 1", tag, pulses);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++;
        if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++;
        if (rdata_last !== 1'b0) begin errors++; $display("FAIL reset_rdata_last: got %b want 0", rdata_last); end
        checks++;
        if (wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready: got %b want 0", wdata_ready); end
        checks++;
        if (wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read_basic();
        do_read(16'h1234, "read_1234");
    endtask

    task automatic test_write_gaps();
        do_write(16'h0040, 32'hA000_0000, 1'b1, 1'b0, "write_gaps");
        do_read(16'h004F, "read_004f");
    endtask

    task automatic test_back_to_back();
        logic        exp_valid;
        logic [31:0] exp_d;
        int          e2;
        e2 = LAT + LW + 1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0200;
        @(posedge clk); #1;
        req_addr = 16'h0300;
        for (int n = 0; n <= e2 + LAT + LW; n++) begin
            exp_valid = 1'b0;
            exp_d     = 32'h0;
            if (n >= LAT && n < LAT + LW) begin
                exp_valid = 1'b1;
                exp_d     = 32'h0200 + 32'(n - LAT);
            end else if (n >= e2 + LAT && n < e2 + LAT + LW) begin
                exp_valid = 1'b1;
                exp_d     = 32'h0300 + 32'(n - e2 - LAT);
            end
            checks++;
            if (rdata_valid !== exp_valid) begin
                errors++;
                $display("FAIL b2b_valid n=%0d: got %b want %b", n, rdata_valid, exp_valid);
            end
            checks++;
            if (req_ready !== (n == LAT + LW || n == e2 + LAT + LW)) begin
                errors++;
                $display("FAIL b2b_req_ready n=%0d: got %b want %b", n, req_ready, (n == LAT + LW || n == e2 + LAT + LW));
            end
            if (exp_valid) begin
                checks++;
                if (rdata !== exp_d) begin
                    errors++;
                    $display("FAIL b2b_data n=%0d: got %h want %h", n, rdata, exp_d);
                end
            end
            if (n == e2) req_valid = 1'b0;
            if (n < e2 + LAT + LW) begin
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_read_top();
        do_read(16'hFFF5, "read_top");
    endtask

    task automatic test_reset_mid_write();
        int k;
        k = 0;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready_pre: got %b want 1", req_ready); end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        for (int n = 0; n < LAT + LW && k < 5; n++) begin
            if (n >= LAT) begin
                wdata_valid = 1'b1;
                wdata       = 32'hB000_0000 + 32'(k);
            end
            @(posedge clk); #1;
            if (n >= LAT) begin
                model[16'h0100 + 16'(k)] = 32'hB000_0000 + 32'(k);
                k++;
            end
        end
        checks++;
        if (wdata_ready !== 1'b1) begin errors++; $display("FAIL rstw_in_burst: got %b want 1", wdata_ready); end
        #2;
        rst = 1'b1;
        wdata_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rstw_req_ready: got %b want 0", req_ready); end
        checks++;
        if (wdata_ready !== 1'b0) begin errors++; $display("FAIL rstw_wdata_ready: got %b want 0", wdata_ready); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL rstw_rdata: got %h want 0", rdata); end
        checks++;
        if (rdata_valid !== 1'b0 || rdata_last !== 1'b0 || wr_done !== 1'b0) begin
            errors++;
            $display("FAIL rstw_flags: got %b%b%b want 000", rdata_valid, rdata_last, wr_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || wr_done !== 1'b0) begin
            errors++;
            $display("FAIL rstw_idle: got ready=%b done=%b want ready=1 done=0", req_ready, wr_done);
        end
        do_read(16'h0100, "rstw_read");
    endtask

    task automatic test_write_valid_in_lat();
        do_write(16'h0080, 32'hC000_0000, 1'b0, 1'b1, "write_lat");
        do_read(16'h0085, "read_0080");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) model[i] = 32'(i);
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 16'h0;
        wdata_valid = 1'b0;
        wdata       = 32'h0;
        test_reset();
        test_read_basic();
        test_write_gaps();
        test_back_to_back();
        test_read_top();
        test_reset_mid_write();
        test_write_valid_in_lat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_line_server.md
# mem_line_server

Main-memory responder for the data cache's line refill and writeback traffic. It accepts one line request at a time over a valid/ready handshake and waits a fixed access latency. A read then streams the aligned line back one word per cycle. A write absorbs the line one word per accepted beat and signals completion. It sits below the cache and owns the 64K-word backing store.

## Interface
- `ADDR_W`, default 16: word address width; the store holds 2^ADDR_W words of 32 bits.
- `LINE_WORDS`, default 16: words per line; must be a power of 2 and at least 2.
- `LATENCY`, default 4: rising edges from request accept to the first data beat; must be at least 1.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: responder can accept a request.
- `req_write`, input, 1: 1 = line write, 0 = line read.
- `req_addr`, input, ADDR_W: any word address inside the target line.
- `wdata_valid`, input, 1: write beat present.
- `wdata_ready`, output, 1: write beat accepted this cycle if valid.
- `wdata`, input, 32: write beat data.
- `rdata_valid`, output, 1: read beat valid.
- `rdata`, output, 32: read beat data.
- `rdata_last`, output, 1: final beat of a read line.
- `wr_done`, output, 1: one-cycle pulse when a line write completes.

## Operation
- Store contents at time zero: word i holds i. `rst` never clears the store.
- Line base = `req_addr` with its low log2(LINE_WORDS) bits forced to 0. Beats always run in ascending order base+0 .. base+LINE_WORDS-1. The line never wraps across a line boundary or past the top of memory.
- FSM states:
  - IDLE: `req_ready`=1. On an edge with `req_valid`&`req_ready`, latch the base and `req_write`, load the latency counter, and go to LAT.
  - LAT: count LATENCY edges from accept. Then go to RBURST for a read or WBURST for a write.
  - RBURST: `rdata_valid`=1 on every cycle, with no backpressure. Beat k carries store[base+k]. `rdata_last`=1 on beat LINE_WORDS-1. The edge ending the last beat returns the FSM to IDLE.
  - WBURST: `wdata_ready`=1. Each edge with `wdata_valid`=1 writes `wdata` to store[base+k] and increments k. Gaps between beats are allowed. The edge accepting beat LINE_WORDS-1 moves the FSM to WRESP.
  - WRESP: `wr_done`=1 for exactly one cycle, then IDLE.
- Only one request is outstanding. `req_ready`=0 outside IDLE, and a held `req_valid` is simply not accepted until IDLE. `wdata_valid` is ignored outside WBURST.
- `rdata` holds its last driven value while `rdata_valid`=0.
- The beat counter is log2(LINE_WORDS) bits wide and is cleared on every accept. Address = {base[ADDR_W-1:log2 LINE_WORDS], k}.
- Reset asserted mid-operation:
  - The FSM goes immediately to IDLE and all outputs take their reset values.
  - Write beats already accepted remain in the store; there is no rollback.
  - A partial read line is abandoned.

## Timing
- Reset values: state IDLE, `rdata_valid`=0, `rdata_last`=0, `rdata`=0, `wdata_ready`=0, `wr_done`=0. `req_ready` = (state==IDLE) & !`rst`, so it is 0 while reset is held.
- Read, with accept at edge E: beat k is valid in the cycle after edge E+LATENCY+k. `req_ready` rises in the cycle after the last beat. Accept-to-next-accept is LATENCY+LINE_WORDS+1 edges minimum.
- Write, with accept at edge E: `wdata_ready` is first 1 in the cycle after edge E+LATENCY. `wr_done` is high in the cycle after the edge accepting the final beat. IDLE follows one cycle later.
- Store reads are zero-latency with respect to beat timing. A read issued after a completed write returns the new data.

## Test plan
- Reset with LATENCY=4, then read `req_addr`=0x1234:
  - Base is 0x1230.
  - `rdata_valid` is high for 16 consecutive cycles starting after edge E+4, carrying 0x1230..0x123F.
  - `rdata_last` is high only with 0x123F.
  - `req_ready` is low from accept through the last beat.
- Write 0x0040 with `wdata`=0xA000_0000+k, `wdata_valid` toggling every other cycle:
  - Exactly 16 beats are accepted.
  - A single `wr_done` pulse follows the 16th beat.
  - A subsequent read of 0x004F returns 0xA000_0000..0xA000_000F.
- Two reads with `req_valid` held high throughout:
  - The second is accepted on the first IDLE edge after the first line's last beat.
  - The second request is ignored while busy, and no beats overlap.
- Read 0xFFF5: returns words 0xFFF0..0xFFFF in order, with no wrap to 0x0000.
- Write to 0x0100, with `rst` asserted asynchronously mid-cycle after 5 accepted beats:
  - All outputs go to reset values immediately.
  - A read of 0x0100 afterwards returns 5 new words followed by 0x0105..0x010F.
- Write request with `wdata_valid`=1 during LAT: no store change and no beat counted before `wdata_ready` rises.
